// File: rtl/tc_alu_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tc_alu_bist_ctrl
//
// BIST controller for the 8-bit TC ALU.
//
// In functional mode (TEST_EN=0) the chip pins A_in/B_in/sel_in pass straight
// through to the ALU. In test mode (TEST_EN=1) a SET_EN strobe does three
// things: it seeds a 16-bit Fibonacci LFSR, it clears a 16-bit MISR, and it
// starts a run of PATTERNS pseudo-random patterns.
//
// The LFSR drives A/B/sel. The MISR compacts the 16-bit ALU result on every
// RUN edge. One cycle after the last capture, the signature is compared
// against GOLDEN. The registered PASS_N/DONE pair then reports the outcome.
//
// The MISR is scannable MSB-first through SI/SI_EN/SO while the controller
// is in IDLE or DONE.
//
// Optional build macro BIST_SIG_OUT_EN adds an output port SIG[15:0]. SIG
// carries the live MISR contents for debug readout.
// ---------------------------------------------------------------------------
module tc_alu_bist_ctrl #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          PATTERNS = 32,
    parameter logic [15:0] GOLDEN   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        TEST_EN,
    input  logic        SET_EN,
    input  logic        SI,
    input  logic        SI_EN,
    input  logic [7:0]  A_in,
    input  logic [7:0]  B_in,
    input  logic        sel_in,
    input  logic [15:0] Y,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic        sel,
    output logic        SO,
    output logic        PASS_N,
    output logic        DONE
`ifdef BIST_SIG_OUT_EN
    ,
    output logic [15:0] SIG
`endif
);

    // Counter is wide enough to hold PATTERNS itself, which is the value
    // the counter reaches on the edge that enters CMP.
    localparam int CW = $clog2(PATTERNS + 1);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [CW-1:0] LAST_CNT = CW'(PATTERNS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Feedback parity for x^16+x^14+x^13+x^11+1 (taps 15,13,12,10).
    function automatic logic fb_parity(input logic [15:0] v);
        fb_parity = v[15] ^ v[13] ^ v[12] ^ v[10];
    endfunction

    // One LFSR shift.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        lfsr_step = {l[14:0], fb_parity(l)};
    endfunction

    // One MISR compaction step absorbing result word y.
    function automatic logic [15:0] misr_step(input logic [15:0] m,
                                              input logic [15:0] y);
        misr_step = {m[14:0], fb_parity(m)} ^ y;
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [15:0]     lfsr_r;
    logic [15:0]     lfsr_s;
    logic [15:0]     misr_r;
    logic [15:0]     misr_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_s;
    logic            pass_n_r;
    logic            pass_n_s;
    logic            done_r;
    logic            done_s;

    // State and datapath registers with asynchronous reset to the IDLE picture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            lfsr_r   <= SEED_EFF;
            misr_r   <= 16'h0000;
            count_r  <= {CW{1'b0}};
            pass_n_r <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            lfsr_r   <= lfsr_s;
            misr_r   <= misr_s;
            count_r  <= count_s;
            pass_n_r <= pass_n_s;
            done_r   <= done_s;
        end
    end

    // Next-state and next-datapath logic.
    // Priority order is: leaving test mode, then SET_EN restart, then the
    // per-state behaviour.
    always_comb begin
        state_s  = state_r;
        lfsr_s   = lfsr_r;
        misr_s   = misr_r;
        count_s  = count_r;
        pass_n_s = pass_n_r;
        done_s   = done_r;

        if (!TEST_EN) begin
            // Functional mode: park in IDLE. LFSR and MISR hold, except that
            // an already idle controller still accepts scan shifts.
            state_s  = ST_IDLE;
            pass_n_s = 1'b1;
            done_s   = 1'b0;
            if ((state_r == ST_IDLE) && SI_EN) begin
                misr_s = {misr_r[14:0], SI};
            end else begin
                misr_s = misr_r;
            end
        end else if (SET_EN) begin
            // Seed / restart from any state. This takes priority over a RUN
            // capture and over a scan shift.
            state_s  = ST_RUN;
            lfsr_s   = SEED_EFF;
            misr_s   = 16'h0000;
            count_s  = {CW{1'b0}};
            pass_n_s = 1'b1;
            done_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pass_n_s = 1'b1;
                    done_s   = 1'b0;
                    if (SI_EN) begin
                        misr_s = {misr_r[14:0], SI};
                    end else begin
                        misr_s = misr_r;
                    end
                end
                ST_RUN: begin
                    // Absorb the result of the pattern on the bus right now,
                    // then move to the next pattern. SI_EN is ignored here.
                    misr_s  = misr_step(misr_r, Y);
                    lfsr_s  = lfsr_step(lfsr_r);
                    count_s = count_r + CW'(1);
                    if (count_r == LAST_CNT) begin
                        state_s = ST_CMP;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_CMP: begin
                    pass_n_s = (misr_r != GOLDEN);
                    done_s   = 1'b1;
                    state_s  = ST_DONE;
                end
                ST_DONE: begin
                    // Verdict holds; the signature may be scanned out.
                    if (SI_EN) begin
                        misr_s = {misr_r[14:0], SI};
                    end else begin
                        misr_s = misr_r;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    pass_n_s = 1'b1;
                    done_s   = 1'b0;
                end
            endcase
        end
    end

    // ALU operand mux: the LFSR drives the ALU in test mode, the pins otherwise.
    always_comb begin
        if (TEST_EN) begin
            A   = lfsr_r[15:8];
            B   = lfsr_r[7:0];
            sel = lfsr_r[0];
        end else begin
            A   = A_in;
            B   = B_in;
            sel = sel_in;
        end
    end

    assign SO     = misr_r[15];
    assign PASS_N = pass_n_r;
    assign DONE   = done_r;

`ifdef BIST_SIG_OUT_EN
    assign SIG = misr_r;
`endif

endmodule

// File: tb/tb_tc_alu_bist_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for tc_alu_bist_ctrl.
//
// A behavioural TC ALU closes the loop from A/B/sel back to Y:
//   sel=0 -> Y = sign-extended A+B
//   sel=1 -> Y = signed 8x8 product
//
// The golden signatures come from a reference walk of the LFSR and MISR
// equations over that ALU.
//
// A second instance uses SEED=0 and PATTERNS=2. It covers the zero-seed
// replacement and the minimum run length.
// ---------------------------------------------------------------------------
module tb_tc_alu_bist_ctrl;

    function automatic logic [15:0] alu_model(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic       s);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        if (s) alu_model = 16'(sa * sb);
        else   alu_model = 16'(sa + sb);
    endfunction

    function automatic logic [15:0] lfsr_after(input logic [15:0] seed,
                                               input int          n);
        logic [15:0] l;
        l = (seed == 16'h0000) ? 16'h0001 : seed;
        for (int i = 0; i < n; i++) begin
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        return l;
    endfunction

    function automatic logic [15:0] ref_sig(input logic [15:0] seed,
                                            input int          n);
        logic [15:0] l;
        logic [15:0] m;
        l = (seed == 16'h0000) ? 16'h0001 : seed;
        m = 16'h0000;
        for (int i = 0; i < n; i++) begin
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]}
                ^ alu_model(l[15:8], l[7:0], l[0]);
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD1 = ref_sig(16'hACE1, 32);
    localparam logic [15:0] GOLD2 = ref_sig(16'h0000, 2);

    logic clk = 1'b0;
    logic rst;
    logic test_en, set_en, si, si_en, sel_in, stuck;
    logic [7:0] a_in, b_in;

    logic [7:0]  a1, b1, a2, b2;
    logic        sel1, sel2, so1, so2, pass1, pass2, done1, done2;
    logic [15:0] y1, y2;
`ifdef BIST_SIG_OUT_EN
    logic [15:0] sig1, sig2;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] gold_v;
    logic [15:0] pat_v;
    logic [15:0] lf_v;

    always #5 clk = ~clk;

    assign y1 = alu_model(a1, b1, sel1) | (stuck ? 16'h0008 : 16'h0000);
    assign y2 = alu_model(a2, b2, sel2);

    tc_alu_bist_ctrl #(.SEED(16'hACE1), .PATTERNS(32), .GOLDEN(GOLD1)) u_dut (
        .clk(clk), .rst(rst), .TEST_EN(test_en), .SET_EN(set_en),
        .SI(si), .SI_EN(si_en), .A_in(a_in), .B_in(b_in), .sel_in(sel_in),
        .Y(y1), .A(a1), .B(b1), .sel(sel1), .SO(so1), .PASS_N(pass1),
        .DONE(done1)
`ifdef BIST_SIG_OUT_EN
        , .SIG(sig1)
`endif
    );

    tc_alu_bist_ctrl #(.SEED(16'h0000), .PATTERNS(2), .GOLDEN(GOLD2)) u_dut2 (
        .clk(clk), .rst(rst), .TEST_EN(test_en), .SET_EN(set_en),
        .SI(1'b0), .SI_EN(1'b0), .A_in(a_in), .B_in(b_in), .sel_in(sel_in),
        .Y(y2), .A(a2), .B(b2), .sel(sel2), .SO(so2), .PASS_N(pass2),
        .DONE(done2)
`ifdef BIST_SIG_OUT_EN
        , .SIG(sig2)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; test_en = 1'b0; set_en = 1'b0; si = 1'b0; si_en = 1'b0;
        a_in = 8'h12; b_in = 8'h34; sel_in = 1'b0; stuck = 1'b0;
        gold_v = GOLD1; pat_v = 16'hA5A5;
        #2;
        chk("rst_A",      16'(a1),    16'h0012);
        chk("rst_B",      16'(b1),    16'h0034);
        chk("rst_PASS_N", 16'(pass1), 16'h0001);
        chk("rst_DONE",   16'(done1), 16'h0000);
        chk("rst_SO",     16'(so1),   16'h0000);
        step(); step();
        rst = 1'b0;
        step();

        // Run 1: fault-free. Edge 0 samples SET_EN.
        test_en = 1'b1; set_en = 1'b1;
        step();
        set_en = 1'b0;
        chk("e0_A",   16'(a1),   16'h00AC);
        chk("e0_B",   16'(b1),   16'h00E1);
        chk("e0_sel", 16'(sel1), 16'h0001);
        chk("e0_PASS_N", 16'(pass1), 16'h0001);
        chk("z_e0_A", 16'(a2),   16'h0000);
        chk("z_e0_B", 16'(b2),   16'h0001);
        step();
        chk("e1_A",   16'(a1),   16'h0059);
        chk("e1_B",   16'(b1),   16'h00C3);
        chk("e1_sel", 16'(sel1), 16'h0001);
        chk("z_e1_B", 16'(b2),   16'h0002);
        step();
        chk("z_e2_DONE", 16'(done2), 16'h0000);
        step();
        chk("z_e3_DONE",   16'(done2), 16'h0001);
        chk("z_e3_PASS_N", 16'(pass2), 16'h0000);
        repeat (29) step();
        chk("e32_DONE", 16'(done1), 16'h0000);
        step();
        chk("e33_DONE",   16'(done1), 16'h0001);
        chk("e33_PASS_N", 16'(pass1), 16'h0000);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_DONE",   16'(done1), 16'h0001);
            chk("hold_PASS_N", 16'(pass1), 16'h0000);
            chk("hold_SO",     16'(so1),   16'(gold_v[15]));
        end

        // Run 2: Y bit 3 stuck-at-1, restarted from DONE.
        stuck = 1'b1; set_en = 1'b1;
        step();
        set_en = 1'b0;
        chk("f_e0_DONE",   16'(done1), 16'h0000);
        chk("f_e0_PASS_N", 16'(pass1), 16'h0001);
        repeat (32) step();
        chk("f_e32_DONE", 16'(done1), 16'h0000);
        step();
        chk("f_e33_DONE",   16'(done1), 16'h0001);
        chk("f_e33_PASS_N", 16'(pass1), 16'h0001);
        stuck = 1'b0;

        // Run 3: abort after 10 RUN edges by dropping TEST_EN.
        set_en = 1'b1;
        step();
        set_en = 1'b0;
        repeat (10) step();
        test_en = 1'b0; a_in = 8'h5A; b_in = 8'h3C; sel_in = 1'b0;
        step();
        chk("ab_DONE",   16'(done1), 16'h0000);
        chk("ab_PASS_N", 16'(pass1), 16'h0001);
        chk("ab_A",      16'(a1),    16'h005A);
        chk("ab_B",      16'(b1),    16'h003C);
        chk("ab_sel",    16'(sel1),  16'h0000);
        test_en = 1'b1;
        #1;
        lf_v = lfsr_after(16'hACE1, 10);
        chk("ab_lfsr_hold", {a1, b1}, lf_v);
        repeat (40) step();
        chk("ab_idle_DONE", 16'(done1), 16'h0000);
        chk("ab_idle_lfsr", {a1, b1}, lf_v);

        // Run 4: full rerun; SI_EN toggled during RUN must have no effect.
        set_en = 1'b1;
        step();
        set_en = 1'b0; si_en = 1'b1; si = 1'b1;
        repeat (20) step();
        si_en = 1'b0; si = 1'b0;
        repeat (12) step();
        chk("r_e32_DONE", 16'(done1), 16'h0000);
        step();
        chk("r_e33_DONE",   16'(done1), 16'h0001);
        chk("r_e33_PASS_N", 16'(pass1), 16'h0000);

        // Scan 16'hA5A5 in MSB-first while the old signature comes out.
        si_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("scan_out_sig", 16'(so1), 16'(gold_v[15-i]));
            si = pat_v[15-i];
            step();
        end
`ifdef BIST_SIG_OUT_EN
        chk("scan_SIG", sig1, 16'hA5A5);
`endif
        chk("scan_PASS_N", 16'(pass1), 16'h0000);
        chk("scan_DONE",   16'(done1), 16'h0001);
        si = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("scan_out_pat", 16'(so1), 16'(pat_v[15-i]));
            step();
        end
        si_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
